// File: rtl/song_note_sequencer_pkg.sv
// Shared encodings for the song note sequencer: FSM states, score ROM field
// positions and display shift codes.
package song_note_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Score ROM word: {note[7:0], shift[1:0], dur[5:0]}
  localparam int NOTE_MSB  = 15;
  localparam int NOTE_LSB  = 8;
  localparam int SHIFT_MSB = 7;
  localparam int SHIFT_LSB = 6;
  localparam int DUR_MSB   = 5;
  localparam int DUR_LSB   = 0;
  localparam int DUR_W     = DUR_MSB - DUR_LSB + 1;

  localparam logic [1:0] SHIFT_HIGH = 2'b10;
  localparam logic [1:0] SHIFT_LOW  = 2'b01;
  localparam logic [1:0] SHIFT_MID  = 2'b00;

  // The unused code 2'b11 is shown as the middle octave.
  function automatic logic [1:0] decode_shift(input logic [1:0] raw);
    return (raw == 2'b11) ? SHIFT_MID : raw;
  endfunction

endpackage

// File: rtl/song_note_sequencer_tick.sv
// Scroll-rate tick generator: free-running counter while enabled, one-cycle
// tick on the last count of each period.
module seq_tick_gen #(
  parameter int TICK_PERIOD = 100000
) (
  input  logic vga_clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge vga_clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/song_note_sequencer.sv
// Autoplay source for the play-mode display: walks the score ROM and drives
// note/shift/output_ready at the display scroll tick rate.
module song_note_sequencer
  import song_note_sequencer_pkg::*;
#(
  parameter int TICK_PERIOD = 100000,
  parameter int ADDR_W      = 6,
  parameter int GAP_TICKS   = 1
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        note,
  output logic [1:0]        shift,
  output logic              output_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0]     LAST_GAP  = GW'(GAP_TICKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [DUR_W-1:0] dur_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             tick;
  logic             enter_fetch;
  logic             note_end;
  logic             gap_end;

  logic [7:0]       rom_note;
  logic [1:0]       rom_shift;
  logic [DUR_W-1:0] rom_dur;

  assign rom_note  = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_shift = rom_data[SHIFT_MSB:SHIFT_LSB];
  assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];

  assign note_end  = tick && (dur_cnt == DUR_W'(1));
  assign gap_end   = tick && (gap_cnt == LAST_GAP);
  assign dbg_state = state;

  seq_tick_gen #(
    .TICK_PERIOD (TICK_PERIOD)
  ) u_tick (
    .vga_clk (vga_clk),
    .rst     (rst),
    .en      (busy),
    .clr     (enter_fetch),
    .tick    (tick)
  );

  // stop overrides every transition, including a start in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_FETCH;
      ST_FETCH: state_n = ST_WAIT;
      ST_WAIT:  state_n = (rom_dur == '0) ? ST_DONE : ST_PLAY;
      ST_PLAY:  if (note_end) state_n = ST_GAP;
      ST_GAP:   if (gap_end) state_n = (rom_addr == LAST_ADDR) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    if (stop) state_n = ST_IDLE;
    enter_fetch = (state_n == ST_FETCH) && (state != ST_FETCH);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rom_addr     <= '0;
      note         <= '0;
      shift        <= SHIFT_MID;
      output_ready <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dur_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
      done  <= 1'b0;
      if (stop) begin
        rom_addr     <= '0;
        note         <= '0;
        shift        <= SHIFT_MID;
        output_ready <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) rom_addr <= '0;
          end
          ST_WAIT: begin
            if (rom_dur == '0) begin
              done <= 1'b1;
            end else begin
              dur_cnt      <= rom_dur;
              gap_cnt      <= '0;
              note         <= rom_note;
              shift        <= decode_shift(rom_shift);
              output_ready <= (rom_note != 8'h00);
            end
          end
          ST_PLAY: begin
            if (tick) dur_cnt <= dur_cnt - 1'b1;
            // shift is deliberately held through the gap
            if (note_end) begin
              note         <= '0;
              output_ready <= 1'b0;
            end
          end
          ST_GAP: begin
            if (gap_end) begin
              gap_cnt <= '0;
              if (rom_addr == LAST_ADDR) done <= 1'b1;
              else rom_addr <= rom_addr + 1'b1;
            end else if (tick) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          ST_DONE: begin
            rom_addr <= '0;
            shift    <= SHIFT_MID;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_note_sequencer.sv
// Self-checking bench for song_note_sequencer with a small score ROM model;
// output changes are scored against a queue of time-stamped expected events.
module tb_song_note_sequencer;

  localparam int TP = 4;
  localparam int AW = 3;
  localparam int EW = 29;

  logic          vga_clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic [7:0]    note;
  logic [1:0]    shift;
  logic          output_ready;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  logic [15:0]   rom [8];
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            fails  = 0;
  int            cyc    = 0;
  int            t0     = 0;
  bit            mon_en = 1'b0;
  logic [12:0]   prev_snap;

  song_note_sequencer #(
    .TICK_PERIOD (TP),
    .ADDR_W      (AW),
    .GAP_TICKS   (1)
  ) dut (
    .vga_clk      (vga_clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note         (note),
    .shift        (shift),
    .output_ready (output_ready),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // clock / reset / ROM model
  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;
  always @(posedge vga_clk) rom_data <= rom[rom_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: every change of the output snapshot is one event
  always @(negedge vga_clk) begin
    logic [12:0]   cur;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    if (mon_en) begin
      cur = {note, shift, output_ready, done, busy};
      if (cur !== prev_snap) begin
        got = {16'(cyc - t0), cur};
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event got rel=%0d note=%h shift=%b ordy=%b done=%b busy=%b expected=none",
                   got[28:13], got[12:5], got[4:3], got[2], got[1], got[0]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL event got rel=%0d note=%h shift=%b ordy=%b done=%b busy=%b expected rel=%0d note=%h shift=%b ordy=%b done=%b busy=%b",
                     got[28:13], got[12:5], got[4:3], got[2], got[1], got[0],
                     e[28:13], e[12:5], e[4:3], e[2], e[1], e[0]);
          end
        end
        prev_snap = cur;
      end
    end
  end

  // driver tasks: each ends 1 time unit after a rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit fresh);
    start = 1'b1;
    if (fresh) t0 = cyc;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic push_ev(input int rel, input logic [7:0] n, input logic [1:0] s,
                         input logic o, input logic d, input logic b);
    exp_q.push_back({16'(rel), n, s, o, d, b});
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] expv);
    checks++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycles(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout got=%0d_pending expected=0_pending", name, exp_q.size());
      exp_q.delete();
    end
    cycles(6);
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 16'h0000;
  endtask

  initial begin
    logic [7:0]    n;
    logic [1:0]    raw;
    logic [1:0]    sh;
    logic [AW:0]   addr_seq[$];
    logic [AW-1:0] last_addr;
    bit            finished;

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    clear_rom();
    cycles(3);
    rst = 1'b0;
    cycles(1);

    check("reset_note", 16'(note), 16'h0000);
    check("reset_shift", 16'(shift), 16'h0000);
    check("reset_ordy", 16'(output_ready), 16'h0000);
    check("reset_busy", 16'(busy), 16'h0000);
    check("reset_done", 16'(done), 16'h0000);
    check("reset_addr", 16'(rom_addr), 16'h0000);
    check("reset_state", 16'(dbg_state), 16'h0000);

    prev_snap = {note, shift, output_ready, done, busy};
    mon_en    = 1'b1;

    // 1: single C, mid, dur 2, then terminator
    clear_rom();
    rom[0] = 16'h0102;
    push_ev(1,  8'h00, 2'b00, 0, 0, 1);
    push_ev(3,  8'h01, 2'b00, 1, 0, 1);
    push_ev(9,  8'h00, 2'b00, 0, 0, 1);
    push_ev(15, 8'h00, 2'b00, 0, 1, 1);
    push_ev(16, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    wait_drain("single_note", 100);

    // 2: repeated E high, separated by a gap
    clear_rom();
    rom[0] = 16'h0481;
    rom[1] = 16'h0481;
    push_ev(1,  8'h00, 2'b00, 0, 0, 1);
    push_ev(3,  8'h04, 2'b10, 1, 0, 1);
    push_ev(5,  8'h00, 2'b10, 0, 0, 1);
    push_ev(11, 8'h04, 2'b10, 1, 0, 1);
    push_ev(13, 8'h00, 2'b10, 0, 0, 1);
    push_ev(19, 8'h00, 2'b10, 0, 1, 1);
    push_ev(20, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    wait_drain("repeat_note", 100);

    // 3: rest low for 3 ticks, then G mid
    clear_rom();
    rom[0] = 16'h0043;
    rom[1] = 16'h1001;
    push_ev(1,  8'h00, 2'b00, 0, 0, 1);
    push_ev(3,  8'h00, 2'b01, 0, 0, 1);
    push_ev(19, 8'h10, 2'b00, 1, 0, 1);
    push_ev(21, 8'h00, 2'b00, 0, 0, 1);
    push_ev(27, 8'h00, 2'b00, 0, 1, 1);
    push_ev(28, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    wait_drain("rest_then_note", 100);

    // 4: full ROM without terminator, shift codes cycling including 2'b11
    push_ev(1, 8'h00, 2'b00, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      n   = 8'h01 << (i % 7);
      raw = 2'(i % 4);
      sh  = (raw == 2'b11) ? 2'b00 : raw;
      rom[i] = {n, raw, 6'd1};
      push_ev(8 * i + 3, n,     sh, 1, 0, 1);
      push_ev(8 * i + 5, 8'h00, sh, 0, 0, 1);
    end
    push_ev(65, 8'h00, 2'b00, 0, 1, 1);
    push_ev(66, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    last_addr = rom_addr;
    finished  = 1'b0;
    for (int k = 0; k < 200 && !finished; k++) begin
      @(negedge vga_clk);
      if (rom_addr != last_addr) begin
        addr_seq.push_back({busy, rom_addr});
        last_addr = rom_addr;
      end
      if (!busy) finished = 1'b1;
    end
    check("full_rom_addr_changes", 16'(addr_seq.size()), 16'd8);
    for (int i = 0; i < 8 && i < addr_seq.size(); i++) begin
      check("full_rom_addr_seq", 16'(addr_seq[i]), (i < 7) ? 16'(8 + i + 1) : 16'h0000);
    end
    cycles(1);
    wait_drain("full_rom", 100);

    // 5: stop during PLAY of entry 1, then replay from address 0
    clear_rom();
    rom[0] = 16'h0102;
    rom[1] = 16'h0242;
    push_ev(1,  8'h00, 2'b00, 0, 0, 1);
    push_ev(3,  8'h01, 2'b00, 1, 0, 1);
    push_ev(9,  8'h00, 2'b00, 0, 0, 1);
    push_ev(15, 8'h02, 2'b01, 1, 0, 1);
    push_ev(19, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    cycles(17);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("stop_addr", 16'(rom_addr), 16'h0000);
    check("stop_state", 16'(dbg_state), 16'h0000);
    wait_drain("stop_play", 50);
    push_ev(1,  8'h00, 2'b00, 0, 0, 1);
    push_ev(3,  8'h01, 2'b00, 1, 0, 1);
    push_ev(9,  8'h00, 2'b00, 0, 0, 1);
    push_ev(15, 8'h02, 2'b01, 1, 0, 1);
    push_ev(21, 8'h00, 2'b01, 0, 0, 1);
    push_ev(27, 8'h00, 2'b01, 0, 1, 1);
    push_ev(28, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    wait_drain("replay", 100);

    // 6a: start while busy has no effect
    clear_rom();
    rom[0] = 16'h0101;
    push_ev(1,  8'h00, 2'b00, 0, 0, 1);
    push_ev(3,  8'h01, 2'b00, 1, 0, 1);
    push_ev(5,  8'h00, 2'b00, 0, 0, 1);
    push_ev(11, 8'h00, 2'b00, 0, 1, 1);
    push_ev(12, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    cycles(3);
    pulse_start(0);
    wait_drain("start_busy", 100);

    // 6b: start and stop together stay idle
    start = 1'b1;
    stop  = 1'b1;
    cycles(1);
    start = 1'b0;
    stop  = 1'b0;
    cycles(5);
    check("start_stop_busy", 16'(busy), 16'h0000);
    check("start_stop_state", 16'(dbg_state), 16'h0000);

    // 6c: reset in the gap after entry 1
    clear_rom();
    rom[0] = 16'h0181;
    rom[1] = 16'h0282;
    push_ev(1,  8'h00, 2'b00, 0, 0, 1);
    push_ev(3,  8'h01, 2'b10, 1, 0, 1);
    push_ev(5,  8'h00, 2'b10, 0, 0, 1);
    push_ev(11, 8'h02, 2'b10, 1, 0, 1);
    push_ev(17, 8'h00, 2'b10, 0, 0, 1);
    push_ev(19, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    cycles(17);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst_gap_addr", 16'(rom_addr), 16'h0000);
    check("rst_gap_state", 16'(dbg_state), 16'h0000);
    wait_drain("rst_gap", 50);

    // after reset a fresh song keeps the same tick phase
    clear_rom();
    rom[0] = 16'h0102;
    push_ev(1,  8'h00, 2'b00, 0, 0, 1);
    push_ev(3,  8'h01, 2'b00, 1, 0, 1);
    push_ev(9,  8'h00, 2'b00, 0, 0, 1);
    push_ev(15, 8'h00, 2'b00, 0, 1, 1);
    push_ev(16, 8'h00, 2'b00, 0, 0, 0);
    pulse_start(1);
    wait_drain("after_reset", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
